// File: rtl/lif_mon_pkg.sv
// Shared types, width defaults and helpers for the LIF spike monitor.
// Optional feature macro: LIF_MON_BURST_EN (burst flag on report).
package lif_mon_pkg;

    localparam int unsigned WIN_W_DEFAULT  = 8;
    localparam int unsigned CNT_W_DEFAULT  = 8;
    localparam int unsigned ISI_W_DEFAULT  = 8;
    localparam int unsigned VMEM_W_DEFAULT = 7;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } mon_state_e;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned width);
        longint unsigned max_val;
        max_val = (64'd1 << width) - 64'd1;
        if (64'(val) >= max_val) begin
            return val;
        end
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/lif_isi_timer.sv
// Inter-spike interval timer: counts enabled cycles since the last spike and
// presents the completed interval on the cycle of the next spike.
// Optional feature macro: LIF_MON_BURST_EN (not used in this file).
module lif_isi_timer
    import lif_mon_pkg::*;
#(
    parameter int unsigned ISI_W = ISI_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             spk,
    output logic             isi_valid,
    output logic [ISI_W-1:0] isi_value
);

    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             armed_q, armed_d;

    // Next-state: restart on each spike, otherwise count saturating; first spike only arms.
    always_comb begin
        isi_cnt_d = isi_cnt_q;
        armed_d   = armed_q;
        isi_valid = 1'b0;
        // Interval ending at this cycle is the elapsed count plus this cycle.
        isi_value = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));
        if (clear) begin
            isi_cnt_d = '0;
            armed_d   = 1'b0;
        end else if (enable) begin
            if (spk) begin
                isi_valid = armed_q;
                isi_cnt_d = '0;
                armed_d   = 1'b1;
            end else begin
                isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isi_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            isi_cnt_q <= isi_cnt_d;
            armed_q   <= armed_d;
        end
    end

endmodule

// File: rtl/lif_spike_monitor.sv
// Windowed spike statistics for the LIF neuron core: spike count, latest ISI
// and peak membrane potential per window, emitted as one valid/ready report.
// Optional feature macro: LIF_MON_BURST_EN (adds BURST_ISI parameter and rpt_burst logic).
module lif_spike_monitor
    import lif_mon_pkg::*;
#(
    parameter int unsigned WIN_W  = WIN_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter int unsigned ISI_W  = ISI_W_DEFAULT,
    parameter int unsigned VMEM_W = VMEM_W_DEFAULT
`ifdef LIF_MON_BURST_EN
    ,
    parameter int unsigned BURST_ISI = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              spike_in,
    input  logic [VMEM_W-1:0] v_mem_in,
    input  logic [WIN_W-1:0]  win_len,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [CNT_W-1:0]  rpt_count,
    output logic [ISI_W-1:0]  rpt_isi,
    output logic [VMEM_W-1:0] rpt_vpeak,
    output logic              rpt_burst,
    output logic              overrun
);

    mon_state_e        state_q, state_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, cnt_nxt;
    logic [VMEM_W-1:0] acc_peak_q, acc_peak_d, peak_nxt;
    logic [ISI_W-1:0]  acc_isi_q, acc_isi_d, isi_nxt;
    logic              spike_q;
    logic              rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
    logic [ISI_W-1:0]  rpt_isi_q, rpt_isi_d;
    logic [VMEM_W-1:0] rpt_vpeak_q, rpt_vpeak_d;
    logic              overrun_q, overrun_d;
    logic              spk;
    logic              isi_valid;
    logic [ISI_W-1:0]  isi_value;
`ifdef LIF_MON_BURST_EN
    logic              acc_burst_q, acc_burst_d, burst_nxt;
    logic              rpt_burst_q, rpt_burst_d;
`endif

    // Edge detect runs every cycle; gating by enable happens where spikes are consumed.
    assign spk = spike_in & ~spike_q;

    lif_isi_timer #(
        .ISI_W (ISI_W)
    ) u_isi_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .enable    (enable),
        .spk       (spk),
        .isi_valid (isi_valid),
        .isi_value (isi_value)
    );

    // Window FSM, accumulators and report slot next-state.
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        acc_peak_d  = acc_peak_q;
        acc_isi_d   = acc_isi_q;
        rpt_valid_d = rpt_valid_q;
        rpt_count_d = rpt_count_q;
        rpt_isi_d   = rpt_isi_q;
        rpt_vpeak_d = rpt_vpeak_q;
        overrun_d   = overrun_q;
        // Accumulator values including the current cycle.
        cnt_nxt     = spk ? CNT_W'(sat_inc(32'(acc_cnt_q), CNT_W)) : acc_cnt_q;
        peak_nxt    = (v_mem_in > acc_peak_q) ? v_mem_in : acc_peak_q;
        isi_nxt     = isi_valid ? isi_value : acc_isi_q;
`ifdef LIF_MON_BURST_EN
        acc_burst_d = acc_burst_q;
        rpt_burst_d = rpt_burst_q;
        burst_nxt   = acc_burst_q | (isi_valid && (32'(isi_value) <= BURST_ISI));
`endif

        if (clear) begin
            state_d     = IDLE;
            win_cnt_d   = '0;
            acc_cnt_d   = '0;
            acc_peak_d  = '0;
            acc_isi_d   = '0;
            rpt_valid_d = 1'b0;
            rpt_count_d = '0;
            rpt_isi_d   = '0;
            rpt_vpeak_d = '0;
            overrun_d   = 1'b0;
`ifdef LIF_MON_BURST_EN
            acc_burst_d = 1'b0;
            rpt_burst_d = 1'b0;
`endif
        end else begin
            if (rpt_valid_q && rpt_ready) begin
                rpt_valid_d = 1'b0;
            end
            if (enable) begin
                unique case (state_q)
                    IDLE: begin
                        if (win_len != '0) begin
                            state_d    = RUN;
                            win_cnt_d  = win_len;
                            acc_cnt_d  = '0;
                            acc_peak_d = '0;
                            acc_isi_d  = '0;
`ifdef LIF_MON_BURST_EN
                            acc_burst_d = 1'b0;
`endif
                        end
                    end
                    RUN: begin
                        if (win_cnt_q == WIN_W'(1)) begin
                            // Last window cycle: hand off or drop, then restart back-to-back.
                            if (!rpt_valid_q || rpt_ready) begin
                                rpt_valid_d = 1'b1;
                                rpt_count_d = cnt_nxt;
                                rpt_isi_d   = isi_nxt;
                                rpt_vpeak_d = peak_nxt;
`ifdef LIF_MON_BURST_EN
                                rpt_burst_d = burst_nxt;
`endif
                            end else begin
                                overrun_d = 1'b1;
                            end
                            acc_cnt_d  = '0;
                            acc_peak_d = '0;
                            acc_isi_d  = '0;
`ifdef LIF_MON_BURST_EN
                            acc_burst_d = 1'b0;
`endif
                            if (win_len == '0) begin
                                state_d   = IDLE;
                                win_cnt_d = '0;
                            end else begin
                                win_cnt_d = win_len;
                            end
                        end else begin
                            acc_cnt_d  = cnt_nxt;
                            acc_peak_d = peak_nxt;
                            acc_isi_d  = isi_nxt;
                            win_cnt_d  = win_cnt_q - WIN_W'(1);
`ifdef LIF_MON_BURST_EN
                            acc_burst_d = burst_nxt;
`endif
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State registers; spike_q samples every cycle so edges during pauses are consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            win_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            acc_peak_q  <= '0;
            acc_isi_q   <= '0;
            spike_q     <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_count_q <= '0;
            rpt_isi_q   <= '0;
            rpt_vpeak_q <= '0;
            overrun_q   <= 1'b0;
`ifdef LIF_MON_BURST_EN
            acc_burst_q <= 1'b0;
            rpt_burst_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_peak_q  <= acc_peak_d;
            acc_isi_q   <= acc_isi_d;
            spike_q     <= spike_in;
            rpt_valid_q <= rpt_valid_d;
            rpt_count_q <= rpt_count_d;
            rpt_isi_q   <= rpt_isi_d;
            rpt_vpeak_q <= rpt_vpeak_d;
            overrun_q   <= overrun_d;
`ifdef LIF_MON_BURST_EN
            acc_burst_q <= acc_burst_d;
            rpt_burst_q <= rpt_burst_d;
`endif
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign rpt_count = rpt_count_q;
    assign rpt_isi   = rpt_isi_q;
    assign rpt_vpeak = rpt_vpeak_q;
    assign overrun   = overrun_q;
`ifdef LIF_MON_BURST_EN
    assign rpt_burst = rpt_burst_q;
`else
    assign rpt_burst = 1'b0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Self-checking bench for lif_spike_monitor: directed scenarios plus a random
// phase, all checked against a window/report model built from queues.
// Optional feature macro: LIF_MON_BURST_EN (changes expected burst flags).
`timescale 1ns/1ps
module tb_lif_spike_monitor;

    localparam int unsigned WIN_W   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ISI_W   = 8;
    localparam int unsigned VMEM_W  = 7;
    localparam int          CNT_MAX = 255;
    localparam int          ISI_MAX = 255;
`ifdef LIF_MON_BURST_EN
    localparam int          BURST_ISI = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              clear;
    logic              spike_in;
    logic [VMEM_W-1:0] v_mem_in;
    logic [WIN_W-1:0]  win_len;
    logic              rpt_valid;
    logic              rpt_ready;
    logic [CNT_W-1:0]  rpt_count;
    logic [ISI_W-1:0]  rpt_isi;
    logic [VMEM_W-1:0] rpt_vpeak;
    logic              rpt_burst;
    logic              overrun;

    always #5 clk = ~clk;

    lif_spike_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .spike_in  (spike_in),
        .v_mem_in  (v_mem_in),
        .win_len   (win_len),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_count (rpt_count),
        .rpt_isi   (rpt_isi),
        .rpt_vpeak (rpt_vpeak),
        .rpt_burst (rpt_burst),
        .overrun   (overrun)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: per-window sample queues, global enabled-cycle clock.
    bit m_prev;
    bit m_running;
    int m_left;
    int m_ecyc;
    int m_last;
    int q_spk[$];
    int q_v[$];
    int q_isi[$];
    bit e_valid;
    bit e_overrun;
    int e_cnt;
    int e_isi;
    int e_peak;
    bit e_burst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev    = 1'b0;
        m_running = 1'b0;
        m_left    = 0;
        m_last    = -1;
        q_spk.delete();
        q_v.delete();
        q_isi.delete();
        e_valid   = 1'b0;
        e_overrun = 1'b0;
        e_cnt     = 0;
        e_isi     = 0;
        e_peak    = 0;
        e_burst   = 1'b0;
    endtask

    task automatic close_window();
        int s;
        int pk;
        bit b;
        s  = 0;
        pk = 0;
        b  = 1'b0;
        foreach (q_spk[i]) s += q_spk[i];
        foreach (q_v[i]) if (q_v[i] > pk) pk = q_v[i];
`ifdef LIF_MON_BURST_EN
        foreach (q_isi[i]) if (q_isi[i] <= BURST_ISI) b = 1'b1;
`endif
        if (!e_valid) begin
            e_valid = 1'b1;
            e_cnt   = (s > CNT_MAX) ? CNT_MAX : s;
            e_peak  = pk;
            e_isi   = (q_isi.size() > 0) ? q_isi[q_isi.size()-1] : 0;
            e_burst = b;
        end else begin
            e_overrun = 1'b1;
        end
        q_spk.delete();
        q_v.delete();
        q_isi.delete();
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit edge_now;
        int isi_this;
        edge_now = spike_in && !m_prev;
        m_prev   = spike_in;
        if (clear) begin
            m_running = 1'b0;
            m_last    = -1;
            q_spk.delete();
            q_v.delete();
            q_isi.delete();
            e_valid   = 1'b0;
            e_overrun = 1'b0;
        end else begin
            if (e_valid && rpt_ready) e_valid = 1'b0;
            if (enable) begin
                m_ecyc++;
                isi_this = -1;
                if (edge_now) begin
                    if (m_last >= 0)
                        isi_this = (m_ecyc - m_last > ISI_MAX) ? ISI_MAX : m_ecyc - m_last;
                    m_last = m_ecyc;
                end
                if (!m_running) begin
                    if (win_len != 0) begin
                        m_running = 1'b1;
                        m_left    = int'(win_len);
                    end
                end else begin
                    q_spk.push_back(edge_now ? 1 : 0);
                    q_v.push_back(int'(v_mem_in));
                    if (isi_this >= 0) q_isi.push_back(isi_this);
                    m_left--;
                    if (m_left == 0) begin
                        close_window();
                        if (win_len == 0) m_running = 1'b0;
                        else m_left = int'(win_len);
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", rpt_valid, e_valid);
        chk("overrun", overrun, e_overrun);
        if (e_valid) begin
            chk("count", rpt_count, e_cnt);
            chk("isi", rpt_isi, e_isi);
            chk("vpeak", rpt_vpeak, e_peak);
            chk("burst", rpt_burst, e_burst);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, rpt_valid, 0);
        chk({tag, "_count"}, rpt_count, 0);
        chk({tag, "_isi"}, rpt_isi, 0);
        chk({tag, "_vpeak"}, rpt_vpeak, 0);
        chk({tag, "_burst"}, rpt_burst, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic apply_reset(input string tag);
        reset    = 1'b1;
        spike_in = 1'b0;
        #1;
        model_reset();
        check_zero(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    int saved_cnt;
    int saved_isi;
    int saved_peak;
    bit exp_b;

    initial begin
        m_ecyc    = 0;
        reset     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        spike_in  = 1'b0;
        v_mem_in  = '0;
        win_len   = '0;
        rpt_ready = 1'b0;
        #2;
        apply_reset("reset");

        // 1: spikes at window cycles 2, 5, 9 of a 10-cycle window.
        enable    = 1'b1;
        win_len   = 8'd10;
        rpt_ready = 1'b1;
        tick();
        for (int t = 1; t <= 10; t++) begin
            spike_in = (t == 2 || t == 5 || t == 9);
            v_mem_in = VMEM_W'($urandom_range(0, 127));
            tick();
            if (t == 9) chk("t1_early_valid", rpt_valid, 0);
        end
        spike_in = 1'b0;
        chk("t1_valid", rpt_valid, 1);
        chk("t1_count", rpt_count, 3);
        chk("t1_isi", rpt_isi, 4);

        // 2: ramp 0..90 then 40; spike on the last window cycle.
        do_clear();
        chk("t2_clear_valid", rpt_valid, 0);
        win_len = 8'd11;
        tick();
        for (int t = 1; t <= 11; t++) begin
            v_mem_in = (t <= 10) ? VMEM_W'((t - 1) * 10) : VMEM_W'(40);
            spike_in = (t == 11);
            tick();
        end
        spike_in = 1'b0;
        chk("t2_vpeak", rpt_vpeak, 90);
        chk("t2_count", rpt_count, 1);
        chk("t2_isi", rpt_isi, 0);

        // 3: consumer stalled over two windows.
        do_clear();
        win_len   = 8'd5;
        rpt_ready = 1'b0;
        tick();
        for (int t = 1; t <= 5; t++) begin
            spike_in = ($urandom_range(0, 1) == 1);
            v_mem_in = VMEM_W'($urandom_range(0, 127));
            tick();
        end
        saved_cnt  = e_cnt;
        saved_isi  = e_isi;
        saved_peak = e_peak;
        chk("t3_valid1", rpt_valid, 1);
        for (int t = 1; t <= 5; t++) begin
            spike_in = ($urandom_range(0, 1) == 1);
            v_mem_in = VMEM_W'($urandom_range(0, 127));
            tick();
        end
        chk("t3_hold_count", rpt_count, saved_cnt);
        chk("t3_hold_isi", rpt_isi, saved_isi);
        chk("t3_hold_vpeak", rpt_vpeak, saved_peak);
        chk("t3_overrun", overrun, 1);
        rpt_ready = 1'b1;
        spike_in  = 1'b0;
        tick();
        chk("t3_accept_valid", rpt_valid, 0);
        chk("t3_overrun_sticky", overrun, 1);
        do_clear();
        chk("t3_overrun_cleared", overrun, 0);

        // 4: level held high gives one spike; alternating edges; long ISI saturates.
        win_len = 8'd200;
        tick();
        for (int t = 1; t <= 300; t++) begin
            spike_in = 1'b1;
            v_mem_in = VMEM_W'($urandom_range(0, 127));
            tick();
            if (t == 200) chk("t4_level_count", rpt_count, 1);
        end
        for (int t = 1; t <= 300; t++) begin
            spike_in = t[0];
            tick();
        end
        spike_in = 1'b0;
        do_clear();
        win_len = 8'd255;
        tick();
        for (int t = 1; t <= 510; t++) begin
            spike_in = (t == 1 || t == 301);
            tick();
        end
        chk("t4_isi_sat", rpt_isi, 255);
        chk("t4_isi_count", rpt_count, 1);

        // 5: pause for 5 cycles mid-window with an edge while paused.
        do_clear();
        win_len = 8'd10;
        tick();
        for (int t = 1; t <= 4; t++) begin
            spike_in = (t == 3);
            tick();
        end
        for (int d = 0; d < 5; d++) begin
            enable   = 1'b0;
            spike_in = (d >= 2);
            tick();
        end
        enable = 1'b1;
        for (int t = 5; t <= 10; t++) begin
            spike_in = (t == 5);
            tick();
            if (t == 9) chk("t5_pause_valid", rpt_valid, 0);
        end
        chk("t5_ext_valid", rpt_valid, 1);
        chk("t5_ext_count", rpt_count, 1);
        tick();
        for (int t = 0; t < 4; t++) begin
            spike_in = t[0];
            tick();
        end
        win_len = 8'd0;
        do_clear();
        for (int t = 0; t < 15; t++) begin
            spike_in = t[0];
            tick();
        end
        chk("t5_clear_noreport", rpt_valid, 0);
        // win_len dropping to 0 mid-window ends after this window.
        win_len = 8'd3;
        tick();
        win_len = 8'd0;
        for (int t = 0; t < 3; t++) tick();
        chk("t5_last_valid", rpt_valid, 1);
        for (int t = 0; t < 8; t++) tick();
        chk("t5_idle_valid", rpt_valid, 0);

        // 6: burst flag with ISI 3 and ISI 6.
        do_clear();
        win_len = 8'd20;
        tick();
        for (int t = 1; t <= 40; t++) begin
            spike_in = (t == 2 || t == 5 || t == 23 || t == 29);
            tick();
`ifdef LIF_MON_BURST_EN
            exp_b = (t == 20);
`else
            exp_b = 1'b0;
`endif
            if (t == 20 || t == 40) chk("t6_burst", rpt_burst, exp_b);
        end
        spike_in = 1'b0;

        // Random phase.
        do_clear();
        win_len = 8'd6;
        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(0, 7) != 0);
            spike_in  = ($urandom_range(0, 2) == 0);
            v_mem_in  = VMEM_W'($urandom_range(0, 127));
            rpt_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) win_len = WIN_W'($urandom_range(0, 12));
            tick();
        end
        clear = 1'b0;

        // Reset in the middle of a window.
        do_clear();
        enable  = 1'b1;
        win_len = 8'd10;
        tick();
        for (int t = 0; t < 4; t++) begin
            spike_in = t[0];
            tick();
        end
        apply_reset("midreset");
        for (int t = 0; t < 12; t++) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
